// File: rtl/kc705_eth_pkg.sv
// Shared definitions for the KC705 Ethernet command path: default field
// lengths and the RX unpacker state encoding.
package kc705_eth_pkg;

  localparam int REG_WIDTH     = 4;
  localparam int NUM_REG       = 6;
  localparam int CMD_LENGTH    = 4;
  localparam int PKT_ID_LENGTH = 4;

  typedef enum logic [1:0] {
    ST_CMD   = 2'd0,
    ST_ID    = 2'd1,
    ST_REGS  = 2'd2,
    ST_DRAIN = 2'd3
  } rx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/kc705_axis_byte_to_word.sv
// Big-endian byte accumulator: each accepted byte shifts in at the LSB end,
// word_done flags the byte that completes a NUM_BYTES-byte field.
module kc705_axis_byte_to_word
  import kc705_eth_pkg::*;
#(
  parameter int NUM_BYTES = 4,
  parameter int CNT_W     = 3
) (
  input  logic                   axi_tclk,
  input  logic                   axi_tresetn,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic [7:0]             byte_in,
  output logic [8*NUM_BYTES-1:0] word,
  output logic                   word_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  logic [8*NUM_BYTES-1:0] word_reg;
  logic [CNT_W-1:0]       cnt_reg;

  assign word      = word_reg;
  assign word_done = shift_en && (cnt_reg == LAST_CNT);

  // clr only rewinds the counter; the held word stays visible until overwritten
  always_ff @(posedge axi_tclk) begin
    if (!axi_tresetn) begin
      word_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (shift_en)
        word_reg <= (word_reg << 8) | (8*NUM_BYTES)'(byte_in);
      if (clr || word_done)
        cnt_reg <= '0;
      else if (shift_en)
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/kc705_ethernet_rx_cmd_unpacker.sv
// Splits each RX payload packet into command word, packet ID and a stream of
// register words, flagging packets that end early or run long.
module kc705_ethernet_rx_cmd_unpacker
  import kc705_eth_pkg::*;
#(
  parameter int REG_WIDTH     = kc705_eth_pkg::REG_WIDTH,
  parameter int NUM_REG       = kc705_eth_pkg::NUM_REG,
  parameter int CMD_LENGTH    = kc705_eth_pkg::CMD_LENGTH,
  parameter int PKT_ID_LENGTH = kc705_eth_pkg::PKT_ID_LENGTH
) (
  input  logic                       axi_tclk,
  input  logic                       axi_tresetn,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [8*REG_WIDTH-1:0]     reg_map_axis_tdata,
  output logic                       reg_map_axis_tvalid,
  output logic                       reg_map_axis_tlast,
  input  logic                       reg_map_axis_tready,
  output logic [8*CMD_LENGTH-1:0]    cmd_word,
  output logic [8*PKT_ID_LENGTH-1:0] pkt_id,
  output logic                       cmd_valid,
  output logic                       pkt_short_err,
  output logic                       pkt_long_err
);

  localparam int BYTE_CNT_W = $clog2(max3(REG_WIDTH, CMD_LENGTH, PKT_ID_LENGTH) + 1);
  localparam int REG_IDX_W  = $clog2(NUM_REG + 1);
  localparam logic [REG_IDX_W-1:0] LAST_REG = REG_IDX_W'(NUM_REG - 1);

  rx_state_t              state_reg, state_next;
  logic [REG_IDX_W-1:0]   reg_idx_reg, reg_idx_next;
  logic [8*REG_WIDTH-1:0] out_data_reg, reg_acc_word, reg_word_next;
  logic                   out_valid_reg, out_last_reg;
  logic                   cmd_valid_reg, short_err_reg, long_err_reg;
  logic                   cmd_valid_next, short_err_next, long_err_next, word_load;
  logic                   byte_acc, field_clr;
  logic                   cmd_shift, id_shift, reg_shift;
  logic                   cmd_done, id_done, reg_done;

  assign s_axis_tready = !out_valid_reg | reg_map_axis_tready;
  assign byte_acc      = s_axis_tvalid & s_axis_tready;
  assign field_clr     = byte_acc & s_axis_tlast;
  assign cmd_shift     = byte_acc && (state_reg == ST_CMD);
  assign id_shift      = byte_acc && (state_reg == ST_ID);
  assign reg_shift     = byte_acc && (state_reg == ST_REGS);
  // completed register word, captured in the same edge as its final byte
  assign reg_word_next = (reg_acc_word << 8) | (8*REG_WIDTH)'(s_axis_tdata);

  kc705_axis_byte_to_word #(.NUM_BYTES(CMD_LENGTH), .CNT_W(BYTE_CNT_W)) u_cmd_acc (
    .axi_tclk(axi_tclk), .axi_tresetn(axi_tresetn), .clr(field_clr), .shift_en(cmd_shift),
    .byte_in(s_axis_tdata), .word(cmd_word), .word_done(cmd_done)
  );

  kc705_axis_byte_to_word #(.NUM_BYTES(PKT_ID_LENGTH), .CNT_W(BYTE_CNT_W)) u_id_acc (
    .axi_tclk(axi_tclk), .axi_tresetn(axi_tresetn), .clr(field_clr), .shift_en(id_shift),
    .byte_in(s_axis_tdata), .word(pkt_id), .word_done(id_done)
  );

  kc705_axis_byte_to_word #(.NUM_BYTES(REG_WIDTH), .CNT_W(BYTE_CNT_W)) u_reg_acc (
    .axi_tclk(axi_tclk), .axi_tresetn(axi_tresetn), .clr(field_clr), .shift_en(reg_shift),
    .byte_in(s_axis_tdata), .word(reg_acc_word), .word_done(reg_done)
  );

  always_comb begin
    state_next     = state_reg;
    reg_idx_next   = reg_idx_reg;
    word_load      = 1'b0;
    cmd_valid_next = 1'b0;
    short_err_next = 1'b0;
    long_err_next  = 1'b0;
    if (byte_acc) begin
      case (state_reg)
        ST_CMD: begin
          if (s_axis_tlast) begin
            short_err_next = 1'b1;
          end else if (cmd_done) begin
            state_next = ST_ID;
          end
        end
        ST_ID: begin
          if (s_axis_tlast) begin
            short_err_next = 1'b1;
            state_next     = ST_CMD;
          end else if (id_done) begin
            cmd_valid_next = 1'b1;
            state_next     = ST_REGS;
          end
        end
        ST_REGS: begin
          word_load = reg_done;
          // a tlast that completes the final register is a well-formed end
          if (reg_done && (reg_idx_reg == LAST_REG)) begin
            reg_idx_next = '0;
            state_next   = s_axis_tlast ? ST_CMD : ST_DRAIN;
          end else if (s_axis_tlast) begin
            short_err_next = 1'b1;
            reg_idx_next   = '0;
            state_next     = ST_CMD;
          end else if (reg_done) begin
            reg_idx_next = reg_idx_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (s_axis_tlast) begin
            long_err_next = 1'b1;
            state_next    = ST_CMD;
          end
        end
        default: state_next = ST_CMD;
      endcase
    end
  end

  always_ff @(posedge axi_tclk) begin
    if (!axi_tresetn) begin
      state_reg     <= ST_CMD;
      reg_idx_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      cmd_valid_reg <= 1'b0;
      short_err_reg <= 1'b0;
      long_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      reg_idx_reg   <= reg_idx_next;
      cmd_valid_reg <= cmd_valid_next;
      short_err_reg <= short_err_next;
      long_err_reg  <= long_err_next;
      if (word_load) begin
        out_data_reg  <= reg_word_next;
        out_last_reg  <= (reg_idx_reg == LAST_REG);
        out_valid_reg <= 1'b1;
      end else if (reg_map_axis_tready) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

  assign reg_map_axis_tdata  = out_data_reg;
  assign reg_map_axis_tvalid = out_valid_reg;
  assign reg_map_axis_tlast  = out_last_reg;
  assign cmd_valid           = cmd_valid_reg;
  assign pkt_short_err       = short_err_reg;
  assign pkt_long_err        = long_err_reg;

endmodule

// File: tb/tb_kc705_ethernet_rx_cmd_unpacker.sv
// Scoreboard bench for the RX command unpacker: nominal, backpressure, short,
// long, mid-packet reset and back-to-back packets.
module tb_kc705_ethernet_rx_cmd_unpacker;

  logic        axi_tclk = 1'b0;
  logic        axi_tresetn;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] reg_map_axis_tdata;
  logic        reg_map_axis_tvalid;
  logic        reg_map_axis_tlast;
  logic        reg_map_axis_tready;
  logic [31:0] cmd_word;
  logic [31:0] pkt_id;
  logic        cmd_valid;
  logic        pkt_short_err;
  logic        pkt_long_err;

  always #5 axi_tclk = ~axi_tclk;

  kc705_ethernet_rx_cmd_unpacker dut (
    .axi_tclk(axi_tclk),
    .axi_tresetn(axi_tresetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .reg_map_axis_tdata(reg_map_axis_tdata),
    .reg_map_axis_tvalid(reg_map_axis_tvalid),
    .reg_map_axis_tlast(reg_map_axis_tlast),
    .reg_map_axis_tready(reg_map_axis_tready),
    .cmd_word(cmd_word),
    .pkt_id(pkt_id),
    .cmd_valid(cmd_valid),
    .pkt_short_err(pkt_short_err),
    .pkt_long_err(pkt_long_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int short_seen = 0, long_seen = 0, cmd_seen = 0, words_seen = 0, stall_cycles = 0;
  int exp_short = 0, exp_long = 0;
  logic [32:0] exp_word_q[$];
  logic [63:0] exp_cmd_q[$];
  logic [31:0] pkt_regs[6];
  logic        bp_req = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input logic [31:0] cmd, input logic [31:0] id, input int i);
    logic [31:0] w;
    if (i < 4)       w = cmd;
    else if (i < 8)  w = id;
    else if (i < 32) w = pkt_regs[(i - 8) / 4];
    else             w = 32'hA5A5_0000 + i;
    return w[8*(3 - (i % 4)) +: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    int waited = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    @(negedge axi_tclk);
    while (!s_axis_tready && waited < 1000) begin
      @(negedge axi_tclk);
      waited++;
    end
    if (waited >= 1000) check_eq("s_tready_timeout", waited, 0);
    @(posedge axi_tclk);
    #1;
  endtask

  // Reference model: which words, command reports and errors a packet of len bytes yields
  task automatic send_pkt(input logic [31:0] cmd, input logic [31:0] id, input int len, input logic with_last);
    if (len >= 8 && !(len == 8 && with_last)) exp_cmd_q.push_back({cmd, id});
    for (int k = 0; k < 6; k++)
      if (8 + 4 * (k + 1) <= len) exp_word_q.push_back({(k == 5), pkt_regs[k]});
    if (with_last && len < 32) exp_short++;
    if (with_last && len > 32) exp_long++;
    for (int i = 0; i < len; i++)
      send_byte(pkt_byte(cmd, id, i), with_last && (i == len - 1));
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) begin
      @(posedge axi_tclk);
      #1;
    end
  endtask

  task automatic drain_check(input string tag);
    int t = 0;
    while ((exp_word_q.size() != 0 || exp_cmd_q.size() != 0) && t < 500) begin
      @(posedge axi_tclk);
      #1;
      t++;
    end
    idle(3);
    check_eq({tag, "_words_left"}, exp_word_q.size(), 0);
    check_eq({tag, "_cmds_left"}, exp_cmd_q.size(), 0);
    check_eq({tag, "_short_errs"}, short_seen, exp_short);
    check_eq({tag, "_long_errs"}, long_seen, exp_long);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge axi_tclk);
    check_eq({tag, "_tdata"}, reg_map_axis_tdata, 0);
    check_eq({tag, "_tvalid"}, reg_map_axis_tvalid, 0);
    check_eq({tag, "_tlast"}, reg_map_axis_tlast, 0);
    check_eq({tag, "_cmd_word"}, cmd_word, 0);
    check_eq({tag, "_pkt_id"}, pkt_id, 0);
    check_eq({tag, "_cmd_valid"}, cmd_valid, 0);
    check_eq({tag, "_errs"}, {pkt_short_err, pkt_long_err}, 0);
    check_eq({tag, "_s_tready"}, s_axis_tready, 1);
  endtask

  // Monitor: scoreboard pops, hold-stable checks and error pulse counting
  initial begin : monitor
    logic        prev_stall;
    logic [32:0] prev_word;
    logic [32:0] exp_w;
    logic [63:0] exp_c;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge axi_tclk);
      if (axi_tresetn) begin
        if (prev_stall) begin
          check_eq("hold_valid", reg_map_axis_tvalid, 1);
          check_eq("hold_word", {reg_map_axis_tlast, reg_map_axis_tdata}, prev_word);
        end
        if (reg_map_axis_tvalid && !reg_map_axis_tready) begin
          stall_cycles++;
          check_eq("s_tready_during_stall", s_axis_tready, 0);
        end
        if (reg_map_axis_tvalid && reg_map_axis_tready) begin
          check_eq("word_expected", exp_word_q.size() != 0, 1);
          if (exp_word_q.size() != 0) begin
            exp_w = exp_word_q.pop_front();
            check_eq("reg_word", {reg_map_axis_tlast, reg_map_axis_tdata}, exp_w);
          end
          words_seen++;
          $display("word %0d: data=%h last=%b", words_seen, reg_map_axis_tdata, reg_map_axis_tlast);
        end
        if (cmd_valid) begin
          check_eq("cmd_expected", exp_cmd_q.size() != 0, 1);
          if (exp_cmd_q.size() != 0) begin
            exp_c = exp_cmd_q.pop_front();
            check_eq("cmd_id", {cmd_word, pkt_id}, exp_c);
          end
          cmd_seen++;
          $display("cmd %0d: cmd_word=%h pkt_id=%h", cmd_seen, cmd_word, pkt_id);
        end
        if (pkt_short_err || pkt_long_err) begin
          check_eq("err_exclusive", pkt_short_err & pkt_long_err, 0);
          if (pkt_short_err) short_seen++;
          if (pkt_long_err) long_seen++;
          $display("error pulse: short=%b long=%b", pkt_short_err, pkt_long_err);
        end
        prev_stall = reg_map_axis_tvalid && !reg_map_axis_tready;
        prev_word  = {reg_map_axis_tlast, reg_map_axis_tdata};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Downstream ready: stalls word 0x20000000 for five cycles when requested
  initial begin : bp_ctl
    reg_map_axis_tready = 1'b1;
    forever begin
      @(posedge axi_tclk);
      #1;
      if (bp_req && reg_map_axis_tvalid && reg_map_axis_tdata == 32'h2000_0000) begin
        bp_req = 1'b0;
        reg_map_axis_tready = 1'b0;
        repeat (5) @(posedge axi_tclk);
        #1;
        reg_map_axis_tready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int base_stall, base_cmd, base_words;
    axi_tresetn   = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    for (int k = 0; k < 6; k++) pkt_regs[k] = 32'(k + 1) << 28;
    repeat (3) @(posedge axi_tclk);
    #1;
    check_reset_outputs("reset");
    @(posedge axi_tclk);
    #1;
    axi_tresetn = 1'b1;
    idle(2);

    send_pkt(32'hDEADBEEF, 32'h0000_0001, 32, 1'b1);
    idle(2);
    drain_check("nominal");

    base_stall = stall_cycles;
    bp_req = 1'b1;
    send_pkt(32'hDEADBEEF, 32'h0000_0001, 32, 1'b1);
    idle(2);
    drain_check("backpressure");
    check_eq("bp_stall_cycles", stall_cycles - base_stall, 5);

    send_pkt(32'hDEADBEEF, 32'h0000_0002, 17, 1'b1);
    idle(2);
    send_pkt(32'hDEADBEEF, 32'h0000_0001, 32, 1'b1);
    idle(2);
    drain_check("short");

    send_pkt(32'hDEADBEEF, 32'h0000_0001, 36, 1'b1);
    idle(2);
    drain_check("long");

    send_pkt(32'hDEADBEEF, 32'h0000_0001, 14, 1'b0);
    idle(3);
    axi_tresetn = 1'b0;
    @(posedge axi_tclk);
    #1;
    check_reset_outputs("mid_reset");
    axi_tresetn = 1'b1;
    idle(2);
    send_pkt(32'h0BADF00D, 32'h0000_0003, 32, 1'b1);
    idle(2);
    drain_check("after_reset");

    base_stall = stall_cycles;
    base_cmd   = cmd_seen;
    base_words = words_seen;
    send_pkt(32'hCAFEF00D, 32'h0000_0004, 32, 1'b1);
    for (int k = 0; k < 6; k++) pkt_regs[k] = 32'h0A0B_0C00 + 32'(k);
    send_pkt(32'h12345678, 32'h0000_0005, 32, 1'b1);
    idle(2);
    drain_check("back_to_back");
    check_eq("b2b_stalls", stall_cycles - base_stall, 0);
    check_eq("b2b_cmd_pulses", cmd_seen - base_cmd, 2);
    check_eq("b2b_words", words_seen - base_words, 12);
    check_eq("b2b_last_pkt_id", pkt_id, 32'h0000_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kc705_ethernet_rx_cmd_unpacker.md
Name: kc705_ethernet_rx_cmd_unpacker

Overview:
- Downstream neighbour of the Ethernet RX decoder. Consumes the decoder's 8-bit payload stream (tdata/tvalid/tlast/tready).
- Parses each packet into a command word, a packet ID, and NUM_REG register words of REG_WIDTH bytes.
- Emits the register words as a 32-bit AXI-Stream register-map stream, with tlast on the final register, toward the radar control register file.
- Flags short and long packets.

Parameters:
- REG_WIDTH, 4, register width in bytes; output tdata is 8*REG_WIDTH bits.
- NUM_REG, 6, register words per packet.
- CMD_LENGTH, 4, command word length in bytes.
- PKT_ID_LENGTH, 4, packet ID length in bytes.

Ports:
- axi_tclk  in  1  single clock for the whole block.
- axi_tresetn  in  1  synchronous active-low reset.
- s_axis_tdata  in  8  payload byte from the RX decoder.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tlast  in  1  last payload byte of the packet.
- s_axis_tready  out  1  byte accepted when tvalid&tready.
- reg_map_axis_tdata  out  8*REG_WIDTH  register word.
- reg_map_axis_tvalid  out  1  word valid.
- reg_map_axis_tlast  out  1  asserted with register NUM_REG-1.
- reg_map_axis_tready  in  1  downstream accept.
- cmd_word  out  8*CMD_LENGTH  latched command word.
- pkt_id  out  8*PKT_ID_LENGTH  latched packet ID.
- cmd_valid  out  1  one-cycle pulse when pkt_id completes.
- pkt_short_err  out  1  one-cycle pulse: tlast arrived before all registers completed.
- pkt_long_err  out  1  one-cycle pulse: packet carried bytes beyond the last register.

Behaviour:
- Reset (axi_tresetn=0 sampled at posedge):
  - all outputs 0 (s_axis_tready is combinational, see handshake rules);
  - state=CMD, byte and register counters 0, partial word cleared.
  - Reset mid-packet abandons all partial data; the next accepted byte after reset is command byte 0.
- Byte order: big-endian within every field; the first byte received is the MSB.
- Handshake rules:
  - s_axis_tready = !reg_map_axis_tvalid | reg_map_axis_tready (combinational); a byte is taken only on s_axis_tvalid & s_axis_tready.
  - The output word register holds tdata/tlast stable while tvalid & !tready.
- State machine (advances only on accepted bytes):
  - CMD: shift bytes into cmd_word; after CMD_LENGTH bytes -> ID.
  - ID: shift bytes into pkt_id; on byte PKT_ID_LENGTH-1, pulse cmd_valid next cycle -> REGS.
  - REGS: shift bytes into a REG_WIDTH-byte accumulator. On the last byte of a word:
    - load reg_map_axis_tdata and set tvalid the next cycle (latency 1 clock);
    - reg_map_axis_tlast=1 iff reg_idx==NUM_REG-1;
    - reg_idx increments; after register NUM_REG-1 -> DRAIN, unless that byte had tlast (-> CMD).
  - DRAIN: discard bytes; on tlast pulse pkt_long_err -> CMD.
- s_axis_tlast before the final register byte, in any state:
  - pulse pkt_short_err; discard partial word and counters; no word and no reg_map tlast issued for the incomplete register -> CMD.
  - Already-emitted words stand.
  - A tlast during CMD/ID also leaves cmd_word/pkt_id partially updated, and cmd_valid does not pulse.
- cmd_word and pkt_id hold their values until overwritten by the next packet.
- Counter widths: byte counter $clog2(max(REG_WIDTH,CMD_LENGTH,PKT_ID_LENGTH)+1); reg_idx $clog2(NUM_REG+1). No wrap-around occurs: counters reset on field completion.
- Simultaneous output accept and new word completion: the new word loads in the same cycle the old word is accepted. Full throughput is one byte per clock.
- Errors are pulses, not sticky; both are never asserted in the same cycle.

Decomposition:
- Shared package kc705_eth_pkg holds:
  - state encoding localparams (ST_CMD, ST_ID, ST_REGS, ST_DRAIN);
  - default field lengths (REG_WIDTH, NUM_REG, CMD_LENGTH, PKT_ID_LENGTH), shared with the decoder and TX encoder.
- One natural sub-module: kc705_axis_byte_to_word. A parameterised big-endian byte accumulator that shifts bytes in and reports word completion; used for cmd, id and register fields.

Test Plan:
- Nominal: 32-byte packet, cmd=DEADBEEF, id=00000001, regs 0x10000000..0x50000000 plus 0x60000000, tready=1 -> cmd_valid pulse; 6 words; tlast on 0x60000000; no errors.
- Backpressure: same packet, reg_map_axis_tready low for 5 cycles on word 2 -> s_axis_tready low, word 2 held stable, all 6 words intact and in order.
- Short packet: tlast on byte 17 (mid register 2) -> 2 words out, pkt_short_err pulse, no reg_map tlast; the following nominal packet parses correctly.
- Long packet: 36 bytes -> 6 words with tlast on word 6; last 4 bytes dropped; pkt_long_err pulse on byte 36.
- Reset mid-REGS (after byte 14), then a fresh nominal packet -> all outputs 0 during reset; fresh packet yields correct cmd/id/words.
- Back-to-back packets with continuous s_axis_tvalid -> 12 words, no bubbles, 2 cmd_valid pulses, second pkt_id reported.
